// File: rtl/vec_exec_if.sv
// Operand/result handshake bundle between the decode/execute register
// and the vector execute unit.
interface vec_exec_if #(
    parameter int W = 64
);
    logic         valid_i;
    logic         ready_o;
    logic [2:0]   op_i;
    logic         use_imm_i;
    logic [W-1:0] vecOper1_i;
    logic [W-1:0] vecOper2_i;
    logic [W-1:0] vOperImm_i;
    logic [W-1:0] result_o;
    logic         valid_o;
    logic         result_ready_i;
    logic [1:0]   flags_o;

    modport master (
        output valid_i, op_i, use_imm_i,
        output vecOper1_i, vecOper2_i, vOperImm_i,
        output result_ready_i,
        input  ready_o, result_o, valid_o, flags_o
    );

    modport slave (
        input  valid_i, op_i, use_imm_i,
        input  vecOper1_i, vecOper2_i, vOperImm_i,
        input  result_ready_i,
        output ready_o, result_o, valid_o, flags_o
    );
endinterface

// File: rtl/vec_exec_unit.sv
// Multi-beat execute-stage vector ALU: VECT_LANES elements per cycle,
// result and flags held until the consumer takes them.
module vec_exec_unit #(
    parameter int VECT_LANES = 3,
    parameter int VECT_SIZE  = 8,
    parameter int ELEM_SIZE  = 8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    vec_exec_if.slave  bus
);
    localparam int W     = ELEM_SIZE * VECT_SIZE;
    localparam int BEATS = (VECT_SIZE + VECT_LANES - 1) / VECT_LANES;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int SW    = (ELEM_SIZE > 1) ? $clog2(ELEM_SIZE) : 1;
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEATS - 1);

    localparam logic [2:0] OP_XOR   = 3'b000;
    localparam logic [2:0] OP_ADD   = 3'b001;
    localparam logic [2:0] OP_SUB   = 3'b010;
    localparam logic [2:0] OP_ROTL  = 3'b011;
    localparam logic [2:0] OP_ROTR  = 3'b100;
    localparam logic [2:0] OP_PASSA = 3'b101;
    localparam logic [2:0] OP_AND   = 3'b110;
    localparam logic [2:0] OP_OR    = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } state_t;

    state_t         state_q;
    logic [W-1:0]   a_q;
    logic [W-1:0]   b_q;
    logic [2:0]     op_q;
    logic [W-1:0]   res_q;
    logic           carry_q;
    logic [BW-1:0]  beat_q;
    logic [1:0]     flags_q;
    logic           valid_q;
    logic           ready_q;

    logic [W-1:0]   res_nxt;
    logic           cy_nxt;
    logic [ELEM_SIZE:0] lane;
    int             e;

    // Returns {carry/borrow, element result}
    function automatic logic [ELEM_SIZE:0] elem_op(
        input logic [2:0]           op,
        input logic [ELEM_SIZE-1:0] a,
        input logic [ELEM_SIZE-1:0] b
    );
        logic [2*ELEM_SIZE-1:0] rot;
        logic [SW-1:0]          sh;
        logic [ELEM_SIZE:0]     r;
        sh  = b[SW-1:0];
        rot = '0;
        r   = '0;
        unique case (op)
            OP_XOR:   r = {1'b0, a ^ b};
            OP_ADD:   r = {1'b0, a} + {1'b0, b};
            OP_SUB:   r = {a < b, a - b};
            OP_ROTL: begin
                rot = {a, a} << sh;
                r   = {1'b0, rot[2*ELEM_SIZE-1:ELEM_SIZE]};
            end
            OP_ROTR: begin
                rot = {a, a} >> sh;
                r   = {1'b0, rot[ELEM_SIZE-1:0]};
            end
            OP_PASSA: r = {1'b0, a};
            OP_AND:   r = {1'b0, a & b};
            OP_OR:    r = {1'b0, a | b};
        endcase
        return r;
    endfunction

    always_comb begin
        res_nxt = res_q;
        cy_nxt  = carry_q;
        lane    = '0;
        e       = 0;
        for (int k = 0; k < VECT_LANES; k++) begin
            e = int'(beat_q) * VECT_LANES + k;
            if (e < VECT_SIZE) begin
                lane = elem_op(op_q,
                               a_q[e*ELEM_SIZE +: ELEM_SIZE],
                               b_q[e*ELEM_SIZE +: ELEM_SIZE]);
                res_nxt[e*ELEM_SIZE +: ELEM_SIZE] = lane[ELEM_SIZE-1:0];
                cy_nxt = cy_nxt | lane[ELEM_SIZE];
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            beat_q  <= '0;
            flags_q <= '0;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.valid_i && ready_q) begin
                        a_q     <= bus.vecOper1_i;
                        b_q     <= bus.use_imm_i ? bus.vOperImm_i
                                                 : bus.vecOper2_i;
                        op_q    <= bus.op_i;
                        res_q   <= '0;
                        carry_q <= 1'b0;
                        beat_q  <= '0;
                        flags_q <= '0;
                        ready_q <= 1'b0;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    res_q   <= res_nxt;
                    carry_q <= cy_nxt;
                    beat_q  <= beat_q + BW'(1);
                    if (beat_q == BEAT_LAST) begin
                        flags_q <= {cy_nxt, res_nxt == '0};
                        valid_q <= 1'b1;
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (bus.result_ready_i) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready_o  = ready_q;
    assign bus.valid_o  = valid_q;
    assign bus.result_o = res_q;
    assign bus.flags_o  = flags_q;
endmodule
